// File: rtl/key_scanner_pkg.sv
// Shared types and constants for the 4x4 key matrix scanner.
package key_scanner_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        CANDIDATE,
        PRESSED,
        RELEASE
    } kstate_e;

    // Returns {none, code}: code is the lowest set bit index, none flags an empty frame.
    function automatic logic [KEY_W:0] lowest_key(input logic [NUM_COLS*NUM_ROWS-1:0] frame);
        logic [KEY_W:0] pick;
        pick = {1'b1, {KEY_W{1'b0}}};
        for (int i = NUM_COLS*NUM_ROWS-1; i >= 0; i--) begin
            if (frame[i]) pick = {1'b0, KEY_W'(i)};
        end
        return pick;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// Frame-level debounce FSM; outputs registered, one frame evaluation per frame_vld_i pulse.
// Optional auto-repeat while held is built only with KEY_SCANNER_REPEAT_EN defined.
module key_debounce
    import key_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_vld_i,
    input  logic [KEY_W-1:0] code_i,
    input  logic             none_i,
    output logic [KEY_W-1:0] key_code_o,
    output logic             key_valid_o,
    output logic             key_held_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    if (DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CNT, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    kstate_e          state_q;
    logic [KEY_W-1:0] cand_q;
    logic [KEY_W-1:0] code_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             held_q;

    logic [CNT_W-1:0] cnt_inc;
    logic             same_cand;
    logic             same_key;

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign same_cand = !none_i && (code_i == cand_q);
    assign same_key  = !none_i && (code_i == code_q);

`ifdef KEY_SCANNER_REPEAT_EN
    localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_inc;
    logic             first_done_q;
    logic             rpt_fire;

    assign rpt_inc  = rpt_q + RPT_W'(1);
    assign rpt_fire = first_done_q ? (rpt_inc == RPT_W'(REPEAT_RATE))
                                   : (rpt_inc == RPT_W'(REPEAT_DELAY));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
            rpt_q        <= '0;
            first_done_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (frame_vld_i) begin
                unique case (state_q)
                    IDLE: if (!none_i) begin
                        cand_q <= code_i;
                        cnt_q  <= CNT_W'(1);
                        if (CNT_DONE == CNT_W'(1)) begin
                            state_q <= PRESSED;
                            code_q  <= code_i;
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            state_q <= CANDIDATE;
                        end
                    end
                    CANDIDATE: if (none_i) begin
                        state_q <= IDLE;
                    end else if (same_cand) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_q <= PRESSED;
                            code_q  <= cand_q;
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                        end
                    end else begin
                        cand_q <= code_i;
                        cnt_q  <= CNT_W'(1);
                    end
                    PRESSED: if (!same_key) begin
                        cnt_q <= CNT_W'(1);
                        if (CNT_DONE == CNT_W'(1)) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: if (same_key) begin
                        state_q <= PRESSED;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
`ifdef KEY_SCANNER_REPEAT_EN
            // Repeat timing restarts on every entry to PRESSED.
            if (state_q != PRESSED) begin
                rpt_q        <= '0;
                first_done_q <= 1'b0;
            end else if (frame_vld_i && same_key) begin
                rpt_q <= rpt_fire ? '0 : rpt_inc;
                if (rpt_fire) begin
                    first_done_q <= 1'b1;
                    valid_q      <= 1'b1;
                end
            end
`endif
        end
    end

    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;
endmodule

// File: rtl/key_scanner.sv
// 4x4 matrix scanner: column divider, one-hot active-low drive and frame capture feeding key_debounce.
// Press latency up to (DEBOUNCE_CNT+1)*4*SCAN_DIV+2 cycles; auto-repeat with KEY_SCANNER_REPEAT_EN.
module key_scanner
    import key_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] col,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_held
);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int CI_W    = $clog2(NUM_COLS);
    localparam int FRAME_W = NUM_COLS * NUM_ROWS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_div
        $error("key_scanner: SCAN_DIV must be >= 2");
    end

    logic [DIV_W-1:0]    div_q, div_d;
    logic [CI_W-1:0]     col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q;
    logic [FRAME_W-1:0]  frame_q;
    logic                frame_vld_q;
    logic                tc;
    logic [KEY_W:0]      pick;

    assign tc = (div_q == DIV_LAST);

    always_comb begin
        div_d     = tc ? '0 : div_q + DIV_W'(1);
        col_idx_d = tc ? col_idx_q + CI_W'(1) : col_idx_q;
    end

    // The sample at terminal count belongs to the column being driven now.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            col_idx_q   <= '0;
            col_q       <= ~NUM_COLS'(1);
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            frame_vld_q <= tc && (col_idx_q == CI_W'(NUM_COLS - 1));
            if (tc) begin
                frame_q[col_idx_q*NUM_ROWS +: NUM_ROWS] <= ~rows;
                col_q <= ~(NUM_COLS'(1) << col_idx_d);
            end
        end
    end

    assign pick = lowest_key(frame_q);
    assign col  = col_q;

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame_vld_i(frame_vld_q),
        .code_i     (pick[KEY_W-1:0]),
        .none_i     (pick[KEY_W]),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_held_o (key_held)
    );
endmodule

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven before its rows are sampled (minimum 2).
REQ-002 Parameter DEBOUNCE_CNT, default 8, number of consecutive identical frames needed to accept a press or a release (minimum 1).
REQ-003 Parameter REPEAT_DELAY, default 32, frames held before the first auto-repeat (used only with KEY_SCANNER_REPEAT_EN).
REQ-004 Parameter REPEAT_RATE, default 8, frames between later auto-repeats (used only with KEY_SCANNER_REPEAT_EN).
REQ-005 clk  input  1  the single clock; the reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 rows  input  4  row sense lines of the 4x4 matrix, active-low (pulled up externally).
REQ-008 col  output  4  column strobes, one-hot active-low; exactly one bit low at all times.
REQ-009 key_code  output  4  code of the accepted key, col_idx*4 + row_idx, in the 4-bit select format that strobe consumes.
REQ-010 key_valid  output  1  one-cycle pulse when key_code is newly accepted (or repeated).
REQ-011 key_held  output  1  high while the accepted key is debounced as pressed.

Function
REQ-012 The divider counts 0..SCAN_DIV-1; at terminal count the rows are sampled and col_idx advances mod 4 on the same edge.
REQ-013 col = ~(4'b0001 << col_idx), registered; the sample taken at terminal count belongs to the current col_idx.
REQ-014 The sample (~rows) is stored into frame bits [col_idx*4 +: 4]; the sample for col_idx==3 completes a frame, and the frame is evaluated on the next cycle.
REQ-015 Frame code is the lowest set bit index of the frame; an all-zero frame means "none".
REQ-016 FSM states: IDLE, CANDIDATE, PRESSED, RELEASE, with transitions evaluated only on frame-evaluation cycles.
REQ-017 IDLE: a frame code (not none) latches cand and sets cnt=1, then goes to CANDIDATE, or directly to PRESSED when DEBOUNCE_CNT==1.
REQ-018 CANDIDATE: the same code increments cnt; at cnt==DEBOUNCE_CNT go to PRESSED, key_code<=cand, key_valid=1 for one cycle. A different code relatches cand with cnt=1. None returns to IDLE.
REQ-019 PRESSED: key_held=1; the same code stays; none or a different code goes to RELEASE with cnt=1.
REQ-020 RELEASE: none or a different code increments cnt, and at DEBOUNCE_CNT the FSM goes to IDLE with key_held=0. The same code as key_code returns to PRESSED with no new key_valid.
REQ-021 Leaving RELEASE on a different code ends in IDLE; the new key then debounces from IDLE.
REQ-022 key_code holds its last accepted value after release.
REQ-023 key_valid, key_held and key_code are registered outputs with no combinational path from rows.
REQ-024 Worst-case press latency is (DEBOUNCE_CNT+1)*4*SCAN_DIV+2 cycles.

Reset
REQ-025 Reset values: div=0, col_idx=0, col=4'b1110, frame=0, FSM=IDLE, cnt=0, key_code=0, key_valid=0, key_held=0.
REQ-026 Reset asserted mid-frame or mid-debounce discards all progress, and key_valid stays 0 during reset and on the first cycle after it.

Configuration
REQ-027 With KEY_SCANNER_REPEAT_EN defined, PRESSED counts frames: key_valid pulses (same key_code) after REPEAT_DELAY frames, then every REPEAT_RATE frames while held; the counter clears on entry to PRESSED.
REQ-028 Without KEY_SCANNER_REPEAT_EN, key_valid pulses exactly once per press and no repeat counter is built.

Structure
REQ-029 Package key_scanner_pkg holds the FSM state enum, NUM_COLS=4, NUM_ROWS=4 and the key-code width.
REQ-030 Sub-module key_debounce holds the FSM and counters; key_scanner holds the divider, column drive and frame capture.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 cycles)
REQ-031 Reset release -> col sequence 1110,1101,1011,0111 changing every 4 cycles; key_valid=0 throughout with no keys pressed.
REQ-032 Key 5 (col 1, row 1) held steady -> key_code=4'd5 and a single key_valid pulse no later than cycle 66; key_held=1 until release; release is debounced within 66 cycles.
REQ-033 Key 2 bouncing (pressed/not on alternate frames) for 10 frames, then steady -> exactly one key_valid, and only after 3 steady frames.
REQ-034 Keys 9 and 14 held together -> key_code=4'd9; then key 9 dropped -> release of 9, then key_code=4'd14 accepted with a new pulse.
REQ-035 Reset asserted during CANDIDATE (cnt=2) -> no key_valid; after reset a full 3 frames are required again.
REQ-036 With KEY_SCANNER_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2 and key 0 held for 12 frames after acceptance -> key_valid pulses at acceptance and at +4, +6, +8, +10, +12 frames.
